serial_add_arbiter: RTL

SERIAL_ADD_ARBITER -- requirements
Module: serial_add_arbiter

---
 rtl/serial_add_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/serial_add_arbiter.sv
// Four-requester round-robin arbiter in front of a bit-serial adder (one full adder, registered carry).
// Define CARRY_IN_EN to add a per-requester carry-in port (cin) captured with the operands.
module serial_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   opa,
  input  logic [4*WIDTH-1:0]   opb,
`ifdef CARRY_IN_EN
  input  logic [3:0]           cin,
`endif
  output logic [3:0]           gnt,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           done_id,
  output logic [WIDTH-1:0]     sum,
  output logic                 cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Returns {carry, sum} of a single-bit full add.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d, done_q, done_d, cout_q, cout_d;
  logic [1:0]       done_id_q, done_id_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [1:0]       fa_s;
  logic             found_s, cin_s;
  logic [1:0]       win_s;

  // Round-robin search starting at ptr; first requesting index wins.
  always_comb begin
    found_s = 1'b0;
    win_s   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!found_s && req[ptr_q + 2'(k)]) begin
        found_s = 1'b1;
        win_s   = ptr_q + 2'(k);
      end else begin
        found_s = found_s;
      end
    end
  end

`ifdef CARRY_IN_EN
  assign cin_s = cin[win_s];
`else
  assign cin_s = 1'b0;
`endif

  assign fa_s = full_add(a_q[0], b_q[0], carry_q);

  // Next-state and datapath logic for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    gnt_d     = 4'b0000;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d = S_SHIFT;
          a_d     = opa[win_s*WIDTH +: WIDTH];
          b_d     = opb[win_s*WIDTH +: WIDTH];
          carry_d = cin_s;
          acc_d   = '0;
          cnt_d   = '0;
          id_d    = win_s;
          gnt_d   = 4'b0001 << win_s;
          ptr_d   = win_s + 2'd1;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_SHIFT: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = fa_s[1];
        acc_d   = {fa_s[0], acc_q[WIDTH-1:1]};
        // The last bit goes straight into the result registers so done appears on DONE entry.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d   = S_DONE;
          sum_d     = {fa_s[0], acc_q[WIDTH-1:1]};
          cout_d    = fa_s[1];
          done_id_d = id_q;
          done_d    = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d     = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= 2'd0;
      id_q      <= 2'd0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      gnt_q     <= 4'b0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 2'd0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign sum     = sum_q;
  assign cout    = cout_q;

endmodule
